alu_pipe: RTL
=============

// Module: alu_pipe
// PURPOSE
//   Parametrised, registered successor to the 64-bit execute-stage ALU; sits in EX, drives EX/MEM.
//   Adds XOR/SLT/SLTU/shifts, a valid/ready handshake, registered flags, and an illegal-op flag.
//   Optional iterative multiplier; the block is stallable so MEM back-pressure never drops a result.
// PARAMETERS
//   WIDTH     64   operand/result width; legal 8..64, power of two
//   SHAMT_W   6    shift-amount bits; always $clog2(WIDTH), taken from b[SHAMT_W-1:0]
// PORTS
//   clk        in   1      rising-edge clock
//   reset_n    in   1      synchronous, active-low reset
//   in_valid   in   1      a, b, alu_op valid this cycle
//   in_ready   out  1      block accepts when in_valid && in_ready
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B / shift amount
//   alu_op     in   4      operation code (see alu_pkg)
//   out_valid  out  1      result/flags valid
//   out_ready  in   1      consumer takes result when out_valid && out_ready
//   result     out  WIDTH  registered result
//   zero       out  1      result == 0
//   great      out  1      result != 0 && result[WIDTH-1] == 0 (signed positive)
//   ovf        out  1      signed overflow on ADD/SUB; 0 for all other ops
//   illegal    out  1      alu_op not a defined code; result forced to 0
// BEHAVIOUR
//   Reset (reset_n==0 at posedge): out_valid=0, result=0, zero=0, great=0, ovf=0, illegal=0, FSM=IDLE.
//     Reset mid-multiply aborts it; no result is emitted.
//   Op codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 1100 NOR, 0011 XOR, 0111 SLT (signed),
//     1000 SLTU, 0100 SLL, 0101 SRL, 1101 SRA, 1010 MUL (low WIDTH bits; macro only). Other codes illegal.
//   Arithmetic: ADD/SUB wrap modulo 2^WIDTH.
//     ovf = sign(a)==sign(b') && sign(res)!=sign(a), where b' = b for ADD and ~b+1 for SUB.
//     SLT/SLTU produce 0 or 1 zero-extended. Shift amounts >= WIDTH cannot occur (masked to SHAMT_W).
//   Single-cycle ops: latency 1. An op accepted at edge N appears with out_valid=1 after edge N.
//   Output register holds result and flags stable while out_valid && !out_ready.
//   in_ready = (state==IDLE) && (!out_valid || out_ready). This gives full throughput with no bubbles.
//   Simultaneous pop and push in one cycle: the output register is overwritten with the new op.
//   Illegal op: completes in 1 cycle, result=0, zero=1, great=0, ovf=0, illegal=1. Not silently held.
//   FSM: IDLE -> (accept MUL) -> MUL -> (count==WIDTH-1) -> IDLE, writing the output register.
//     The MUL->IDLE write requires !out_valid || out_ready; otherwise the FSM stays in MUL
//     with the counter frozen.
//   in_ready stays 0 throughout MUL, so only one op is in flight.
// CONFIGURATION
//   ALU_MUL_EN defined: op 1010 runs a radix-2 shift-add multiply over WIDTH cycles.
//     Total latency WIDTH+1 from accept to out_valid.
//   ALU_MUL_EN undefined: op 1010 is illegal (1-cycle, illegal=1). The FSM reduces to IDLE only,
//     and no multiplier logic is synthesised.
// STRUCTURE
//   alu_pkg: 4-bit op localparams (ALU_AND..ALU_MUL), ALU_OP_W=4, and an is_legal_op() function.
//   Sub-module alu_mul_seq (start, busy, done, product; WIDTH param) holds the multiply counter
//     and datapath. It is instantiated only under ALU_MUL_EN.
//   Top level holds the combinational op mux, flag logic, output register and handshake.
// TESTING (WIDTH=64)
//   Reset: hold reset_n=0 for 2 cycles mid-stream -> out_valid=0, all flags 0; next accept works normally.
//   ADD 7FFF..FFFF + 1 -> result 8000..0000, ovf=1, great=0.
//   SUB 5-5 -> result 0, zero=1, great=0, ovf=0.
//   Back-pressure: stream AND, OR, SLT(-1,1) with out_ready low for 3 cycles ->
//     results held stable, in_ready=0, then 0/.../1 delivered in order with no loss or duplicates.
//   Shifts: SRA 8000..0000 by 4 -> F800..0000. SLL 1 by 63 -> 8000..0000.
//     SRL 8000..0000 by 63 -> 1.
//   Illegal op 1111 -> out_valid next cycle, illegal=1, result=0.
//     With ALU_MUL_EN: MUL 3*5 -> 15 after 65 cycles, in_ready=0 throughout.
//     Without ALU_MUL_EN: op 1010 -> illegal=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Op codes, FSM state type and legality check shared by the execute-stage ALU.
// ALU_MUL_EN makes op 1010 (MUL) a legal code; otherwise it decodes as illegal.
package alu_pkg;

    localparam int ALU_OP_W = 4;

    localparam logic [ALU_OP_W-1:0] ALU_AND  = 4'b0000;
    localparam logic [ALU_OP_W-1:0] ALU_OR   = 4'b0001;
    localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'b0010;
    localparam logic [ALU_OP_W-1:0] ALU_XOR  = 4'b0011;
    localparam logic [ALU_OP_W-1:0] ALU_SLL  = 4'b0100;
    localparam logic [ALU_OP_W-1:0] ALU_SRL  = 4'b0101;
    localparam logic [ALU_OP_W-1:0] ALU_SUB  = 4'b0110;
    localparam logic [ALU_OP_W-1:0] ALU_SLT  = 4'b0111;
    localparam logic [ALU_OP_W-1:0] ALU_SLTU = 4'b1000;
    localparam logic [ALU_OP_W-1:0] ALU_MUL  = 4'b1010;
    localparam logic [ALU_OP_W-1:0] ALU_NOR  = 4'b1100;
    localparam logic [ALU_OP_W-1:0] ALU_SRA  = 4'b1101;

    typedef enum logic {ST_IDLE, ST_MUL} alu_state_t;

    function automatic logic is_legal_op(input logic [ALU_OP_W-1:0] op);
        logic legal;
        case (op)
            ALU_AND, ALU_OR, ALU_ADD, ALU_XOR, ALU_SLL, ALU_SRL,
            ALU_SUB, ALU_SLT, ALU_SLTU, ALU_NOR, ALU_SRA: legal = 1'b1;
`ifdef ALU_MUL_EN
            ALU_MUL: legal = 1'b1;
`endif
            default: legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Radix-2 shift-add multiplier, one partial product per cycle over WIDTH cycles.
// Only built when ALU_MUL_EN is defined; done holds with the product until the next start.
`ifdef ALU_MUL_EN
module alu_mul_seq #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc_p1;
    logic [WIDTH-1:0] mcand_p1;
    logic [WIDTH-1:0] mplier_p1;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            busy <= 1'b0;
            done <= 1'b0;
            cnt  <= '0;
        end else if (start) begin
            busy <= 1'b1;
            done <= 1'b0;
            cnt  <= '0;
        end else if (busy) begin
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(WIDTH - 1)) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
        end
    end

    // Stage 1: accumulate; only the low WIDTH bits of the product are kept
    always_ff @(posedge clk) begin
        if (start) begin
            acc_p1    <= '0;
            mcand_p1  <= a;
            mplier_p1 <= b;
        end else if (busy) begin
            if (mplier_p1[0])
                acc_p1 <= acc_p1 + mcand_p1;
            mcand_p1  <= mcand_p1 << 1;
            mplier_p1 <= mplier_p1 >> 1;
        end
    end

    assign product = acc_p1;

endmodule
`endif

// File: rtl/alu_pipe.sv
// Registered execute-stage ALU with valid/ready handshake, result flags and illegal-op flag.
// Define ALU_MUL_EN to add the iterative multiplier (op 1010) and the IDLE/MUL sequencer.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH   = 64,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    input  logic [ALU_OP_W-1:0] alu_op,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    result,
    output logic                zero,
    output logic                great,
    output logic                ovf,
    output logic                illegal
);

    logic accept;
    logic alu_load;

    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;
    logic signed [WIDTH-1:0] sra_p0;
    logic        [WIDTH-1:0] b_neg;
    logic        [SHAMT_W-1:0] shamt;
    logic        [WIDTH-1:0] res_p0;
    logic                    ovf_p0;
    logic                    ill_p0;

    assign accept = in_valid && in_ready;

`ifdef ALU_MUL_EN
    alu_state_t       state;
    logic             mul_start;
    logic             mul_busy;
    logic             mul_done;
    logic             mul_wb;
    logic [WIDTH-1:0] mul_prod;

    assign in_ready  = (state == ST_IDLE) && (!out_valid || out_ready);
    assign mul_start = accept && (alu_op == ALU_MUL);
    assign alu_load  = accept && (alu_op != ALU_MUL);
    // A finished product waits in the multiplier until the output register is free
    assign mul_wb    = (state == ST_MUL) && mul_done && !mul_busy && (!out_valid || out_ready);

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_prod)
    );
`else
    assign in_ready = !out_valid || out_ready;
    assign alu_load = accept;
`endif

    // Stage 0: combinational op select
    assign a_s    = a;
    assign b_s    = b;
    assign shamt  = b[SHAMT_W-1:0];
    assign sra_p0 = a_s >>> shamt;
    assign b_neg  = ~b + WIDTH'(1);

    always_comb begin
        res_p0 = '0;
        ovf_p0 = 1'b0;
        ill_p0 = !is_legal_op(alu_op);
        case (alu_op)
            ALU_AND:  res_p0 = a & b;
            ALU_OR:   res_p0 = a | b;
            ALU_NOR:  res_p0 = ~(a | b);
            ALU_XOR:  res_p0 = a ^ b;
            ALU_ADD: begin
                res_p0 = a + b;
                ovf_p0 = (a[WIDTH-1] == b[WIDTH-1]) && (res_p0[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SUB: begin
                res_p0 = a + b_neg;
                ovf_p0 = (a[WIDTH-1] == b_neg[WIDTH-1]) && (res_p0[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SLT:  res_p0 = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
            ALU_SLTU: res_p0 = {{(WIDTH-1){1'b0}}, (a < b)};
            ALU_SLL:  res_p0 = a << shamt;
            ALU_SRL:  res_p0 = a >> shamt;
            ALU_SRA:  res_p0 = sra_p0;
            default:  res_p0 = '0;
        endcase
    end

    function automatic logic is_great(input logic [WIDTH-1:0] r);
        return (r != '0) && !r[WIDTH-1];
    endfunction

    // Stage 1: output register, held while the consumer stalls
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            great     <= 1'b0;
            ovf       <= 1'b0;
            illegal   <= 1'b0;
`ifdef ALU_MUL_EN
            state     <= ST_IDLE;
`endif
        end else begin
            if (alu_load) begin
                out_valid <= 1'b1;
                result    <= res_p0;
                zero      <= (res_p0 == '0);
                great     <= is_great(res_p0);
                ovf       <= ovf_p0;
                illegal   <= ill_p0;
`ifdef ALU_MUL_EN
            end else if (mul_wb) begin
                out_valid <= 1'b1;
                result    <= mul_prod;
                zero      <= (mul_prod == '0);
                great     <= is_great(mul_prod);
                ovf       <= 1'b0;
                illegal   <= 1'b0;
`endif
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
`ifdef ALU_MUL_EN
            if (mul_start)
                state <= ST_MUL;
            else if (mul_wb)
                state <= ST_IDLE;
`endif
        end
    end

endmodule
